// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 4-stage F/D/E/W pipeline.
// Drives the fd/de/ew stage register update codes and the PC write enable,
// resolving load-use stalls, multi-cycle execute occupancy, E-stage redirects
// and the stop instruction. Also keeps a saturating stall-cycle counter.
//
// Update code handshake: each stage register samples its *_update code on
// every rising clk edge. 00 holds the current contents, 01 loads from the
// upstream stage, and 10 loads a bubble. 11 is never driven.
module pipeline_ctrl #(
    parameter int WAIT_W  = 5,
    parameter int STALL_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         d_rs,
    input  logic [6:0]         d_rt,
    input  logic               d_use_rs,
    input  logic               d_use_rt,
    input  logic [1:0]         de_rw,
    input  logic [5:0]         de_rd,
    input  logic               de_load,
    input  logic [WAIT_W-1:0]  de_wait_time,
    input  logic               de_stop,
    input  logic               e_redirect,
    input  logic               resume,
    output logic [1:0]         fd_update,
    output logic [1:0]         de_update,
    output logic [1:0]         ew_update,
    output logic               pc_we,
    output logic               halted,
    output logic [STALL_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [1:0] UPD_HOLD  = 2'b00;
    localparam logic [1:0] UPD_ADV   = 2'b01;
    localparam logic [1:0] UPD_FLUSH = 2'b10;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] cnt_next;
    logic              rs_match;
    logic              rt_match;
    logic              load_use;
    logic              apply_rules;

    // Same register-match rule as the forwarding unit: a real write
    // (de_rw != 0) into the same bank and index that D reads.
    assign rs_match = d_use_rs && (de_rw != 2'b00) &&
                      (de_rw[1] == d_rs[6]) && (de_rd == d_rs[5:0]);
    assign rt_match = d_use_rt && (de_rw != 2'b00) &&
                      (de_rw[1] == d_rt[6]) && (de_rd == d_rt[5:0]);
    assign load_use = de_load && (rs_match || rt_match);

    // Next state, counter and update codes; reset forces all stages to bubble.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        fd_update   = UPD_ADV;
        de_update   = UPD_ADV;
        ew_update   = UPD_ADV;
        pc_we       = 1'b1;
        apply_rules = 1'b0;

        case (state)
            RUN: begin
                if (de_wait_time != '0) begin
                    // Entry into a multi-cycle op defers redirect/stop/load-use
                    // to the release cycle; the E instruction stays in de.
                    fd_update  = UPD_HOLD;
                    de_update  = UPD_HOLD;
                    ew_update  = UPD_FLUSH;
                    pc_we      = 1'b0;
                    cnt_next   = de_wait_time;
                    state_next = MULTI;
                end else begin
                    apply_rules = 1'b1;
                end
            end
            MULTI: begin
                if (cnt > WAIT_W'(1)) begin
                    fd_update = UPD_HOLD;
                    de_update = UPD_HOLD;
                    ew_update = UPD_FLUSH;
                    pc_we     = 1'b0;
                    cnt_next  = cnt - WAIT_W'(1);
                end else begin
                    // Release: behave like RUN with the wait time ignored.
                    apply_rules = 1'b1;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            HALT: begin
                fd_update = UPD_HOLD;
                de_update = UPD_HOLD;
                ew_update = UPD_FLUSH;
                pc_we     = 1'b0;
                if (resume) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase

        if (apply_rules) begin
            if (de_stop) begin
                // Stop retires to W; fd keeps the next instruction for resume.
                fd_update  = UPD_HOLD;
                de_update  = UPD_FLUSH;
                ew_update  = UPD_ADV;
                pc_we      = 1'b0;
                state_next = HALT;
            end else if (e_redirect) begin
                // Redirect wins over load-use: the D instruction is squashed.
                fd_update = UPD_FLUSH;
                de_update = UPD_FLUSH;
                ew_update = UPD_ADV;
                pc_we     = 1'b1;
            end else if (load_use) begin
                fd_update = UPD_HOLD;
                de_update = UPD_FLUSH;
                ew_update = UPD_ADV;
                pc_we     = 1'b0;
            end
        end

        if (rst) begin
            fd_update  = UPD_FLUSH;
            de_update  = UPD_FLUSH;
            ew_update  = UPD_FLUSH;
            pc_we      = 1'b0;
            state_next = RUN;
            cnt_next   = '0;
        end
    end

    assign halted = (state == HALT) && !rst;

    // State and occupancy counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Saturating count of cycles where the PC did not advance outside HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (!pc_we && (state != HALT) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, multi-cycle occupancy, redirect,
// stop/resume, mid-operation reset and stall counter saturation.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic [6:0]  d_rs;
    logic [6:0]  d_rt;
    logic        d_use_rs;
    logic        d_use_rt;
    logic [1:0]  de_rw;
    logic [5:0]  de_rd;
    logic        de_load;
    logic [4:0]  de_wait_time;
    logic        de_stop;
    logic        e_redirect;
    logic        resume;
    logic [1:0]  fd_update;
    logic [1:0]  de_update;
    logic [1:0]  ew_update;
    logic        pc_we;
    logic        halted;
    logic [31:0] stall_cycles;
    logic [1:0]  s_fd_update;
    logic [1:0]  s_de_update;
    logic [1:0]  s_ew_update;
    logic        s_pc_we;
    logic        s_halted;
    logic [2:0]  s_stall_cycles;

    int checks;
    int errors;
    int exp_stall;

    pipeline_ctrl #(.WAIT_W(5), .STALL_W(32)) dut (
        .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .de_rw(de_rw), .de_rd(de_rd),
        .de_load(de_load), .de_wait_time(de_wait_time), .de_stop(de_stop),
        .e_redirect(e_redirect), .resume(resume),
        .fd_update(fd_update), .de_update(de_update), .ew_update(ew_update),
        .pc_we(pc_we), .halted(halted), .stall_cycles(stall_cycles)
    );

    // Narrow stall counter instance, used only to observe saturation.
    pipeline_ctrl #(.WAIT_W(5), .STALL_W(3)) dut_sat (
        .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .de_rw(de_rw), .de_rd(de_rd),
        .de_load(de_load), .de_wait_time(de_wait_time), .de_stop(de_stop),
        .e_redirect(e_redirect), .resume(resume),
        .fd_update(s_fd_update), .de_update(s_de_update), .ew_update(s_ew_update),
        .pc_we(s_pc_we), .halted(s_halted), .stall_cycles(s_stall_cycles)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the three update codes packed {fd,de,ew} plus pc_we.
    task automatic chk_upd(input string tag, input logic [5:0] exp_upd, input logic exp_pc);
        chk({tag, "_upd"}, {26'd0, fd_update, de_update, ew_update}, {26'd0, exp_upd});
        chk({tag, "_pc_we"}, {31'd0, pc_we}, {31'd0, exp_pc});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_rs = 7'h00; d_rt = 7'h00; d_use_rs = 1'b0; d_use_rt = 1'b0;
        de_rw = 2'b00; de_rd = 6'h00; de_load = 1'b0; de_wait_time = 5'd0;
        de_stop = 1'b0; e_redirect = 1'b0; resume = 1'b0;
    endtask

    // Directed stimulus sequence.
    initial begin
        checks    = 0;
        errors    = 0;
        exp_stall = 0;
        idle();
        rst = 1'b1;
        #2;
        chk_upd("reset", 6'b10_10_10, 1'b0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_stall", stall_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Independent ALU stream: writes to r1 while D reads r2/r3.
        for (int i = 0; i < 10; i++) begin
            d_rs = 7'(i + 2); d_rt = 7'(i + 3); d_use_rs = 1'b1; d_use_rt = 1'b1;
            de_rw = 2'b01; de_rd = 6'(i + 1); de_load = 1'b0;
            #1;
            chk_upd("alu_stream", 6'b01_01_01, 1'b1);
            tick();
        end
        chk("alu_stream_stall", stall_cycles, 32'(exp_stall));

        // Load-use on rs, same bank.
        idle();
        de_load = 1'b1; de_rw = 2'b01; de_rd = 6'd5; d_rs = 7'h05; d_use_rs = 1'b1;
        #1;
        chk_upd("load_use_rs", 6'b00_10_01, 1'b0);
        tick(); exp_stall++;
        chk("load_use_rs_stall", stall_cycles, 32'(exp_stall));

        // Same index, other bank: no hazard.
        d_rs = 7'h45;
        #1;
        chk_upd("load_other_bank", 6'b01_01_01, 1'b1);
        tick();
        chk("load_other_bank_stall", stall_cycles, 32'(exp_stall));

        // Load-use on rt in bank 1.
        d_use_rs = 1'b0; d_rt = 7'h45; d_use_rt = 1'b1; de_rw = 2'b10;
        #1;
        chk_upd("load_use_rt", 6'b00_10_01, 1'b0);
        tick(); exp_stall++;

        // No write in E: no hazard even if index matches.
        de_rw = 2'b00;
        #1;
        chk_upd("load_no_write", 6'b01_01_01, 1'b1);
        tick();

        // Match but not a load: forwarding covers it.
        de_rw = 2'b10; de_load = 1'b0;
        #1;
        chk_upd("alu_match", 6'b01_01_01, 1'b1);
        tick();
        chk("hazard_stall", stall_cycles, 32'(exp_stall));

        // Multi-cycle wait 3: entry + 2 holds, then release.
        idle();
        de_wait_time = 5'd3;
        #1;
        chk_upd("wait3_entry", 6'b00_00_10, 1'b0);
        tick(); exp_stall++;
        chk_upd("wait3_hold1", 6'b00_00_10, 1'b0);
        tick(); exp_stall++;
        chk_upd("wait3_hold2", 6'b00_00_10, 1'b0);
        tick(); exp_stall++;
        chk_upd("wait3_release", 6'b01_01_01, 1'b1);
        tick();
        chk("wait3_stall", stall_cycles, 32'(exp_stall));

        // Multi-cycle wait 1: a single hold, then release.
        de_wait_time = 5'd1;
        #1;
        chk_upd("wait1_entry", 6'b00_00_10, 1'b0);
        tick(); exp_stall++;
        chk_upd("wait1_release", 6'b01_01_01, 1'b1);
        tick();
        chk("wait1_stall", stall_cycles, 32'(exp_stall));

        // Wait 2 with redirect and load-use both present: deferred to release.
        idle();
        de_wait_time = 5'd2; e_redirect = 1'b1;
        de_load = 1'b1; de_rw = 2'b01; de_rd = 6'd9; d_rs = 7'h09; d_use_rs = 1'b1;
        #1;
        chk_upd("wait2_redir_entry", 6'b00_00_10, 1'b0);
        tick(); exp_stall++;
        chk_upd("wait2_redir_hold", 6'b00_00_10, 1'b0);
        tick(); exp_stall++;
        chk_upd("wait2_redir_release", 6'b10_10_01, 1'b1);
        tick();
        chk("wait2_redir_stall", stall_cycles, 32'(exp_stall));

        // Redirect in RUN with load-use also present.
        de_wait_time = 5'd0;
        #1;
        chk_upd("run_redir_loaduse", 6'b10_10_01, 1'b1);
        tick();

        // Stop: enter HALT, freeze stall counter, then resume.
        idle();
        de_stop = 1'b1;
        #1;
        chk_upd("stop_entry", 6'b00_10_01, 1'b0);
        chk("stop_entry_halted", {31'd0, halted}, 32'd0);
        tick(); exp_stall++;
        de_stop = 1'b0;
        #1;
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk_upd("halt_1", 6'b00_00_10, 1'b0);
        tick();
        chk_upd("halt_2", 6'b00_00_10, 1'b0);
        tick();
        chk("halt_stall_frozen", stall_cycles, 32'(exp_stall));
        resume = 1'b1;
        #1;
        chk_upd("halt_resume_cycle", 6'b00_00_10, 1'b0);
        tick();
        resume = 1'b0;
        #1;
        chk_upd("after_resume", 6'b01_01_01, 1'b1);
        chk("after_resume_halted", {31'd0, halted}, 32'd0);
        tick();
        chk("resume_stall", stall_cycles, 32'(exp_stall));
        chk("sat_stall", {29'd0, s_stall_cycles}, 32'd7);

        // Resume outside HALT is ignored.
        resume = 1'b1;
        #1;
        chk_upd("resume_in_run", 6'b01_01_01, 1'b1);
        tick();
        resume = 1'b0;

        // Reset in the middle of a multi-cycle op (cnt = 2).
        de_wait_time = 5'd3;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk_upd("mid_reset", 6'b10_10_10, 1'b0);
        chk("mid_reset_stall", stall_cycles, 32'd0);
        chk("mid_reset_sat", {29'd0, s_stall_cycles}, 32'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_upd("post_reset_run", 6'b01_01_01, 1'b1);
        tick();
        chk("post_reset_stall", stall_cycles, 32'd0);

        // Fresh wait 1 after reset: counter restarted from zero.
        de_wait_time = 5'd1;
        #1;
        chk_upd("post_reset_wait1_entry", 6'b00_00_10, 1'b0);
        tick();
        chk_upd("post_reset_wait1_release", 6'b01_01_01, 1'b1);
        tick();
        chk("post_reset_wait1_stall", stall_cycles, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
